// File: rtl/lsb_queue_if.sv
// Issue, memory-port and load-broadcast bundle of the load/store buffer.
// The buffer connects through the slave modport; the issuing core,
// memory and result bus sit on the master side.
interface lsb_queue_if #(
  parameter int ROB_W = 5
);
  logic             issue_enable;
  logic             issue_is_store;
  logic [2:0]       issue_funct3;
  logic [ROB_W-1:0] issue_rob_pos;
  logic [31:0]      issue_rs1_val;
  logic [ROB_W-1:0] issue_rs1_tag;
  logic [31:0]      issue_rs2_val;
  logic [ROB_W-1:0] issue_rs2_tag;
  logic [31:0]      issue_imm;

  logic             mem_enable;
  logic             mem_wr;
  logic [2:0]       mem_ls_type;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_store_val;
  logic             mem_done;
  logic [31:0]      mem_load_val;

  logic             out_valid;
  logic [ROB_W-1:0] out_rob_pos;
  logic [31:0]      out_val;

  modport slave (
    input  issue_enable, issue_is_store, issue_funct3, issue_rob_pos,
           issue_rs1_val, issue_rs1_tag, issue_rs2_val, issue_rs2_tag, issue_imm,
           mem_done, mem_load_val,
    output mem_enable, mem_wr, mem_ls_type, mem_addr, mem_store_val,
           out_valid, out_rob_pos, out_val
  );

  modport master (
    output issue_enable, issue_is_store, issue_funct3, issue_rob_pos,
           issue_rs1_val, issue_rs1_tag, issue_rs2_val, issue_rs2_tag, issue_imm,
           mem_done, mem_load_val,
    input  mem_enable, mem_wr, mem_ls_type, mem_addr, mem_store_val,
           out_valid, out_rob_pos, out_val
  );
endinterface

// File: rtl/lsb_queue.sv
// In-order load/store buffer. Entries wait for operands via CDB snooping,
// stores wait for ROB commit, IO loads wait until they head the ROB.
// One memory access is outstanding at a time.
//
// state | meaning
// IDLE  | no access outstanding; start one when the head is executable
// WAIT  | access outstanding for the head entry; pop on mem_done
// DRAIN | flushed load still outstanding; swallow its mem_done silently
module lsb_queue #(
  parameter int          DEPTH   = 16,
  parameter int          ROB_W   = 5,
  parameter int          N_CDB   = 2,
  parameter logic [31:0] IO_BASE = 32'h30000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     clr,
  lsb_queue_if.slave               bus,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     rob_commit_enable,
  input  logic [ROB_W-1:0]         rob_commit_pos,
  input  logic [ROB_W-1:0]         rob_head_pos,
  input  logic [N_CDB-1:0]         cdb_valid,
  input  logic [N_CDB*ROB_W-1:0]   cdb_tag,
  input  logic [N_CDB*32-1:0]      cdb_val
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
  state_t state, state_next;

  logic [DEPTH-1:0] valid, is_store, committed;
  logic [2:0]       funct3  [DEPTH];
  logic [ROB_W-1:0] rob_pos [DEPTH];
  logic [ROB_W-1:0] rs1_tag [DEPTH];
  logic [ROB_W-1:0] rs2_tag [DEPTH];
  logic [31:0]      rs1_val [DEPTH];
  logic [31:0]      rs2_val [DEPTH];
  logic [31:0]      imm     [DEPTH];
  logic [PTR_W-1:0] head, tail;

  logic [DEPTH-1:0] commit_hit, cmt_now, pop_mask, iss_mask, keep;
  logic [DEPTH-1:0] valid_next, committed_next;
  logic [CNT_W-1:0] cmt_cnt, count_next;
  logic [PTR_W-1:0] head_next, tail_next;
  logic             iss_ok, pop, start, load_done, head_ld, exec;
  logic [31:0]      head_addr, ld_ext;
  logic [2:0]       ls_type;
  logic [31:0]      iss_rs1_val, iss_rs2_val;
  logic [ROB_W-1:0] iss_rs1_tag, iss_rs2_tag;

  // Issue-time bypass: an operand produced on the CDB this cycle enters ready.
  always_comb begin
    iss_rs1_val = bus.issue_rs1_val;
    iss_rs1_tag = bus.issue_rs1_tag;
    iss_rs2_val = bus.issue_rs2_val;
    iss_rs2_tag = bus.issue_rs2_tag;
    for (int k = 0; k < N_CDB; k++) begin
      if (cdb_valid[k] && bus.issue_rs1_tag != '0 &&
          bus.issue_rs1_tag == cdb_tag[k*ROB_W +: ROB_W]) begin
        iss_rs1_val = cdb_val[k*32 +: 32];
        iss_rs1_tag = '0;
      end
      if (cdb_valid[k] && bus.issue_rs2_tag != '0 &&
          bus.issue_rs2_tag == cdb_tag[k*ROB_W +: ROB_W]) begin
        iss_rs2_val = cdb_val[k*32 +: 32];
        iss_rs2_tag = '0;
      end
    end
  end

  // Head decode: address, access size, load extension, executability.
  always_comb begin
    head_addr = rs1_val[head] + imm[head];
    head_ld   = valid[head] & ~is_store[head];
    case (funct3[head][1:0])
      2'b00:   ls_type = 3'd1;
      2'b01:   ls_type = 3'd2;
      default: ls_type = 3'd4;
    endcase
    case (funct3[head])
      3'b000:  ld_ext = {{24{bus.mem_load_val[7]}}, bus.mem_load_val[7:0]};
      3'b001:  ld_ext = {{16{bus.mem_load_val[15]}}, bus.mem_load_val[15:0]};
      3'b100:  ld_ext = {24'd0, bus.mem_load_val[7:0]};
      3'b101:  ld_ext = {16'd0, bus.mem_load_val[15:0]};
      default: ld_ext = bus.mem_load_val;
    endcase
    exec = 1'b0;
    if (valid[head] && rs1_tag[head] == '0 && rs2_tag[head] == '0) begin
      if (is_store[head])
        exec = committed[head];
      else
        exec = !clr && (head_addr < IO_BASE || rob_head_pos == rob_pos[head]);
    end
  end

  // Access sequencing: start on executable head, pop on completion.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    pop        = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE: begin
        if (exec) begin
          start      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_done) begin
          state_next = IDLE;
          // A load completing during a flush is simply discarded by the flush.
          if (!(head_ld && clr)) begin
            pop       = 1'b1;
            load_done = head_ld;
          end
        end else if (clr && head_ld) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.mem_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Occupancy bookkeeping: commit, issue, pop and flush for this cycle.
  always_comb begin
    pop_mask = '0;
    iss_mask = '0;
    iss_ok   = bus.issue_enable && !clr && (count != CNT_W'(DEPTH) || pop);
    if (pop)    pop_mask[head] = 1'b1;
    if (iss_ok) iss_mask[tail] = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      commit_hit[i] = valid[i] & is_store[i] & ~committed[i] & rob_commit_enable &
                      (rob_pos[i] == rob_commit_pos);
    cmt_now = committed | commit_hit;
    keep    = valid & cmt_now & ~pop_mask;
    cmt_cnt = '0;
    for (int i = 0; i < DEPTH; i++)
      cmt_cnt = cmt_cnt + {{PTR_W{1'b0}}, keep[i]};
    head_next = head + {{(PTR_W-1){1'b0}}, pop};
    if (clr) begin
      valid_next     = keep;
      committed_next = keep;
      tail_next      = head_next + cmt_cnt[PTR_W-1:0];
      count_next     = cmt_cnt;
    end else begin
      valid_next     = (valid & ~pop_mask) | iss_mask;
      committed_next = cmt_now & valid & ~pop_mask & ~iss_mask;
      tail_next      = tail + {{(PTR_W-1){1'b0}}, iss_ok};
      count_next     = count - {{PTR_W{1'b0}}, pop} + {{PTR_W{1'b0}}, iss_ok};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_next;
  end

  // Entry storage, CDB snooping and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= '0;
      is_store  <= '0;
      committed <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      full      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        funct3[i]  <= '0;
        rob_pos[i] <= '0;
        rs1_tag[i] <= '0;
        rs2_tag[i] <= '0;
        rs1_val[i] <= '0;
        rs2_val[i] <= '0;
        imm[i]     <= '0;
      end
    end else if (rdy) begin
      valid     <= valid_next;
      committed <= committed_next;
      for (int i = 0; i < DEPTH; i++) begin
        for (int k = 0; k < N_CDB; k++) begin
          if (valid[i] && cdb_valid[k] && rs1_tag[i] != '0 &&
              rs1_tag[i] == cdb_tag[k*ROB_W +: ROB_W]) begin
            rs1_val[i] <= cdb_val[k*32 +: 32];
            rs1_tag[i] <= '0;
          end
          if (valid[i] && cdb_valid[k] && rs2_tag[i] != '0 &&
              rs2_tag[i] == cdb_tag[k*ROB_W +: ROB_W]) begin
            rs2_val[i] <= cdb_val[k*32 +: 32];
            rs2_tag[i] <= '0;
          end
        end
      end
      // Written after the snoop loop so a new entry overrides a popped one.
      if (iss_ok) begin
        is_store[tail] <= bus.issue_is_store;
        funct3[tail]   <= bus.issue_funct3;
        rob_pos[tail]  <= bus.issue_rob_pos;
        rs1_val[tail]  <= iss_rs1_val;
        rs1_tag[tail]  <= iss_rs1_tag;
        rs2_val[tail]  <= iss_rs2_val;
        rs2_tag[tail]  <= iss_rs2_tag;
        imm[tail]      <= bus.issue_imm;
      end
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
    end
  end

  // Registered memory request and load-result broadcast.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_enable    <= 1'b0;
      bus.mem_wr        <= 1'b0;
      bus.mem_ls_type   <= '0;
      bus.mem_addr      <= '0;
      bus.mem_store_val <= '0;
      bus.out_valid     <= 1'b0;
      bus.out_rob_pos   <= '0;
      bus.out_val       <= '0;
    end else if (rdy) begin
      bus.mem_enable <= start;
      if (start) begin
        bus.mem_wr        <= is_store[head];
        bus.mem_ls_type   <= ls_type;
        bus.mem_addr      <= head_addr;
        bus.mem_store_val <= is_store[head] ? rs2_val[head] : 32'd0;
      end
      bus.out_valid <= load_done;
      if (load_done) begin
        bus.out_rob_pos <= rob_pos[head];
        bus.out_val     <= ld_ext;
      end
    end
  end
endmodule

// File: tb/tb_lsb_queue.sv
// Bench for lsb_queue: expected memory requests and load results are queued
// as stimulus is driven and matched by a monitor as the DUT produces them.
module tb_lsb_queue;
  localparam int DEPTH = 16;
  localparam int ROB_W = 5;
  localparam int N_CDB = 2;

  logic                   clk = 1'b0;
  logic                   rst, rdy, clr;
  logic                   full;
  logic [4:0]             count;
  logic                   rob_commit_enable;
  logic [ROB_W-1:0]       rob_commit_pos, rob_head_pos;
  logic [N_CDB-1:0]       cdb_valid;
  logic [N_CDB*ROB_W-1:0] cdb_tag;
  logic [N_CDB*32-1:0]    cdb_val;

  lsb_queue_if #(.ROB_W(ROB_W)) bus();

  lsb_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .N_CDB(N_CDB), .IO_BASE(32'h30000)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .bus(bus),
    .full(full), .count(count),
    .rob_commit_enable(rob_commit_enable), .rob_commit_pos(rob_commit_pos),
    .rob_head_pos(rob_head_pos),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic wr; logic [2:0] ty; logic [31:0] sv;} req_t;
  typedef struct {logic [ROB_W-1:0] rob; logic [31:0] val;} out_t;
  req_t exp_req[$];
  out_t exp_out[$];

  int n_checks = 0, n_pass = 0;
  int req_cnt = 0, srv_cnt = 0;
  logic men_prev = 1'b0;

  // Scoreboard monitor: every rising mem_enable and every out_valid must be expected.
  always @(negedge clk) begin
    if (rst) begin
      men_prev = 1'b0;
    end else begin
      if (bus.mem_enable && !men_prev) begin
        req_t e;
        req_cnt++;
        n_checks++;
        if (exp_req.size() == 0) begin
          $display("FAIL mem_req unexpected: addr=%h wr=%0d", bus.mem_addr, bus.mem_wr);
        end else begin
          e = exp_req.pop_front();
          if ({bus.mem_addr, bus.mem_wr, bus.mem_ls_type, bus.mem_store_val} !==
              {e.addr, e.wr, e.ty, e.sv})
            $display("FAIL mem_req got addr=%h wr=%0d ty=%0d sv=%h want addr=%h wr=%0d ty=%0d sv=%h",
                     bus.mem_addr, bus.mem_wr, bus.mem_ls_type, bus.mem_store_val,
                     e.addr, e.wr, e.ty, e.sv);
          else n_pass++;
        end
      end
      men_prev = bus.mem_enable;
      if (bus.out_valid) begin
        out_t o;
        n_checks++;
        if (exp_out.size() == 0) begin
          $display("FAIL out_valid unexpected: rob=%0d val=%h", bus.out_rob_pos, bus.out_val);
        end else begin
          o = exp_out.pop_front();
          if ({bus.out_rob_pos, bus.out_val} !== {o.rob, o.val})
            $display("FAIL load_out got rob=%0d val=%h want rob=%0d val=%h",
                     bus.out_rob_pos, bus.out_val, o.rob, o.val);
          else n_pass++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives an issue for one clock; called at a negedge, returns at the next.
  task automatic do_issue(input logic st, input logic [2:0] f3, input logic [ROB_W-1:0] rob,
                          input logic [31:0] r1, input logic [ROB_W-1:0] t1,
                          input logic [31:0] r2, input logic [ROB_W-1:0] t2,
                          input logic [31:0] im);
    bus.issue_enable   = 1'b1;
    bus.issue_is_store = st;
    bus.issue_funct3   = f3;
    bus.issue_rob_pos  = rob;
    bus.issue_rs1_val  = r1;
    bus.issue_rs1_tag  = t1;
    bus.issue_rs2_val  = r2;
    bus.issue_rs2_tag  = t2;
    bus.issue_imm      = im;
    @(negedge clk);
    bus.issue_enable   = 1'b0;
  endtask

  task automatic commit(input logic [ROB_W-1:0] pos);
    rob_commit_enable = 1'b1;
    rob_commit_pos    = pos;
    @(negedge clk);
    rob_commit_enable = 1'b0;
  endtask

  task automatic wait_req();
    int w = 0;
    while (req_cnt <= srv_cnt && w < 100) begin @(negedge clk); w++; end
    n_checks++;
    if (req_cnt <= srv_cnt) $display("FAIL wait_req timeout: req_cnt=%0d served=%0d", req_cnt, srv_cnt);
    else n_pass++;
  endtask

  task automatic serve(input logic [31:0] v);
    wait_req();
    if (req_cnt > srv_cnt) begin
      srv_cnt++;
      bus.mem_done     = 1'b1;
      bus.mem_load_val = v;
      @(negedge clk);
      bus.mem_done     = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    srv_cnt = req_cnt;
  endtask

  task automatic test_reset();
    apply_reset();
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (count !== 5'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else n_pass++;
    n_checks++; if (bus.mem_enable !== 1'b0) $display("FAIL reset_mem_enable got %b want 0", bus.mem_enable); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out_val !== 32'd0)
      $display("FAIL reset_out got valid=%b val=%h want 0/0", bus.out_valid, bus.out_val); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_ext();
    exp_req.push_back('{32'h104, 1'b0, 3'd4, 32'h0}); exp_out.push_back('{5'd1, 32'hFFFFFF80});
    exp_req.push_back('{32'h104, 1'b0, 3'd1, 32'h0}); exp_out.push_back('{5'd2, 32'hFFFFFF80});
    exp_req.push_back('{32'h104, 1'b0, 3'd1, 32'h0}); exp_out.push_back('{5'd3, 32'h00000080});
    exp_req.push_back('{32'h104, 1'b0, 3'd2, 32'h0}); exp_out.push_back('{5'd4, 32'hFFFF8001});
    exp_req.push_back('{32'h104, 1'b0, 3'd2, 32'h0}); exp_out.push_back('{5'd5, 32'h00008001});
    exp_req.push_back('{32'h0,   1'b0, 3'd4, 32'h0}); exp_out.push_back('{5'd6, 32'h00000001});
    do_issue(1'b0, 3'b010, 5'd1, 32'h100, 5'd0, 32'h0, 5'd0, 32'd4);
    do_issue(1'b0, 3'b000, 5'd2, 32'h100, 5'd0, 32'h0, 5'd0, 32'd4);
    do_issue(1'b0, 3'b100, 5'd3, 32'h0,   5'd6, 32'h0, 5'd0, 32'd4);
    do_issue(1'b0, 3'b001, 5'd4, 32'h100, 5'd0, 32'h0, 5'd0, 32'd4);
    do_issue(1'b0, 3'b101, 5'd5, 32'h100, 5'd0, 32'h0, 5'd0, 32'd4);
    do_issue(1'b0, 3'b010, 5'd6, 32'h10,  5'd0, 32'h0, 5'd0, 32'hFFFFFFF0);
    n_checks++; if (count !== 5'd6) $display("FAIL load_count got %0d want 6", count); else n_pass++;
    cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd6}; cdb_val = {32'h0, 32'h100};
    @(negedge clk);
    cdb_valid = 2'b00;
    serve(32'hFFFFFF80);
    serve(32'hFFFFFF80);
    serve(32'hFFFFFF80);
    serve(32'h00008001);
    serve(32'h00008001);
    serve(32'h00000001);
    cycles(4);
  endtask

  task automatic test_store_commit();
    int base;
    do_issue(1'b1, 3'b010, 5'd3, 32'h200, 5'd0, 32'h0, 5'd3, 32'd0);
    cdb_valid = 2'b10; cdb_tag = {5'd3, 5'd0}; cdb_val = {32'h55, 32'h0};
    @(negedge clk);
    cdb_valid = 2'b00;
    base = req_cnt;
    cycles(5);
    n_checks++; if (req_cnt !== base) $display("FAIL store_before_commit got %0d requests want 0", req_cnt - base); else n_pass++;
    exp_req.push_back('{32'h200, 1'b1, 3'd4, 32'h55});
    commit(5'd3);
    serve(32'h0);
    cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd4}; cdb_val = {32'h0, 32'hABCD};
    do_issue(1'b1, 3'b000, 5'd4, 32'h208, 5'd0, 32'h0, 5'd4, 32'd0);
    cdb_valid = 2'b00;
    exp_req.push_back('{32'h208, 1'b1, 3'd1, 32'hABCD});
    commit(5'd4);
    serve(32'h0);
    cycles(3);
    n_checks++; if (count !== 5'd0) $display("FAIL store_count got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_io_load();
    int base;
    rob_head_pos = 5'd6;
    do_issue(1'b0, 3'b010, 5'd7, 32'h30000, 5'd0, 32'h0, 5'd0, 32'd0);
    base = req_cnt;
    cycles(5);
    n_checks++; if (req_cnt !== base) $display("FAIL io_load_early got %0d requests want 0", req_cnt - base); else n_pass++;
    exp_req.push_back('{32'h30000, 1'b0, 3'd4, 32'h0}); exp_out.push_back('{5'd7, 32'hDEADBEEF});
    rob_head_pos = 5'd7;
    serve(32'hDEADBEEF);
    rob_head_pos = 5'd6;
    exp_req.push_back('{32'h2FFFC, 1'b0, 3'd4, 32'h0}); exp_out.push_back('{5'd8, 32'h5});
    do_issue(1'b0, 3'b010, 5'd8, 32'h2FFF0, 5'd0, 32'h0, 5'd0, 32'hC);
    serve(32'h5);
    rob_head_pos = 5'd0;
    cycles(3);
  endtask

  task automatic test_flush_commit();
    do_issue(1'b1, 3'b010, 5'd1, 32'h300, 5'd0, 32'h11, 5'd0, 32'd0);
    do_issue(1'b1, 3'b010, 5'd2, 32'h304, 5'd0, 32'h22, 5'd0, 32'd0);
    do_issue(1'b0, 3'b010, 5'd3, 32'h400, 5'd0, 32'h0,  5'd0, 32'd0);
    do_issue(1'b0, 3'b010, 5'd4, 32'h404, 5'd0, 32'h0,  5'd0, 32'd0);
    do_issue(1'b0, 3'b010, 5'd5, 32'h408, 5'd0, 32'h0,  5'd0, 32'd0);
    exp_req.push_back('{32'h300, 1'b1, 3'd4, 32'h11});
    exp_req.push_back('{32'h304, 1'b1, 3'd4, 32'h22});
    commit(5'd1);
    commit(5'd2);
    wait_req();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_checks++; if (count !== 5'd2) $display("FAIL flush_count got %0d want 2", count); else n_pass++;
    serve(32'h0);
    serve(32'h0);
    cycles(5);
    n_checks++; if (count !== 5'd0) $display("FAIL flush_drained got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_drain();
    exp_req.push_back('{32'h500, 1'b0, 3'd4, 32'h0});
    do_issue(1'b0, 3'b010, 5'd9, 32'h500, 5'd0, 32'h0, 5'd0, 32'd0);
    wait_req();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_checks++; if (count !== 5'd0) $display("FAIL drain_count got %0d want 0", count); else n_pass++;
    serve(32'h1234);
    cycles(3);
    exp_req.push_back('{32'h504, 1'b0, 3'd2, 32'h0}); exp_out.push_back('{5'd11, 32'h0000BEEF});
    do_issue(1'b0, 3'b101, 5'd11, 32'h500, 5'd0, 32'h0, 5'd0, 32'd4);
    serve(32'h1234BEEF);
    cycles(3);
  endtask

  task automatic test_rdy_freeze();
    rdy = 1'b0;
    do_issue(1'b0, 3'b010, 5'd12, 32'h600, 5'd0, 32'h0, 5'd0, 32'd0);
    rdy = 1'b1;
    @(negedge clk);
    n_checks++; if (count !== 5'd0) $display("FAIL rdy_issue got count %0d want 0", count); else n_pass++;
    exp_req.push_back('{32'h600, 1'b0, 3'd4, 32'h0}); exp_out.push_back('{5'd10, 32'h77});
    do_issue(1'b0, 3'b010, 5'd10, 32'h600, 5'd0, 32'h0, 5'd0, 32'd0);
    wait_req();
    rdy = 1'b0;
    bus.mem_done = 1'b1; bus.mem_load_val = 32'hBAD;
    @(negedge clk);
    bus.mem_done = 1'b0;
    cycles(2);
    n_checks++; if (count !== 5'd1) $display("FAIL rdy_hold got count %0d want 1", count); else n_pass++;
    rdy = 1'b1;
    serve(32'h77);
    cycles(3);
  endtask

  task automatic test_full_wrap();
    apply_reset();
    rob_head_pos = 5'd0;
    for (int r = 1; r <= DEPTH; r++)
      do_issue(1'b0, 3'b010, 5'(r), 32'h30000, 5'd0, 32'h0, 5'd0, 32'(r * 4));
    n_checks++; if (full !== 1'b1) $display("FAIL full_flag got %b want 1", full); else n_pass++;
    n_checks++; if (count !== 5'd16) $display("FAIL full_count got %0d want 16", count); else n_pass++;
    do_issue(1'b0, 3'b010, 5'd20, 32'h30000, 5'd0, 32'h0, 5'd0, 32'd0);
    n_checks++; if (count !== 5'd16) $display("FAIL full_ignore got %0d want 16", count); else n_pass++;
    exp_req.push_back('{32'h30004, 1'b0, 3'd4, 32'h0}); exp_out.push_back('{5'd1, 32'h101});
    rob_head_pos = 5'd1;
    wait_req();
    srv_cnt++;
    bus.mem_done = 1'b1; bus.mem_load_val = 32'h101;
    do_issue(1'b0, 3'b010, 5'd17, 32'h30000, 5'd0, 32'h0, 5'd0, 32'(17 * 4));
    bus.mem_done = 1'b0;
    n_checks++; if (count !== 5'd16 || full !== 1'b1)
      $display("FAIL issue_pop got count=%0d full=%b want 16/1", count, full); else n_pass++;
    for (int r = 2; r <= DEPTH + 1; r++) begin
      exp_req.push_back('{32'(32'h30000 + r * 4), 1'b0, 3'd4, 32'h0});
      exp_out.push_back('{5'(r), 32'(32'h100 + r)});
      rob_head_pos = 5'(r);
      serve(32'(32'h100 + r));
    end
    cycles(3);
    n_checks++; if (count !== 5'd0 || full !== 1'b0)
      $display("FAIL wrap_drained got count=%0d full=%b want 0/0", count, full); else n_pass++;
    rob_head_pos = 5'd0;
  endtask

  task automatic test_reset_midwait();
    exp_req.push_back('{32'h700, 1'b0, 3'd4, 32'h0});
    do_issue(1'b0, 3'b010, 5'd13, 32'h700, 5'd0, 32'h0, 5'd0, 32'd0);
    wait_req();
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.mem_enable !== 1'b0 || count !== 5'd0)
      $display("FAIL async_reset got mem_enable=%b count=%0d want 0/0", bus.mem_enable, count); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    serve(32'h9999);
    cycles(4);
    n_checks++; if (count !== 5'd0) $display("FAIL reset_wait_count got %0d want 0", count); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clr = 1'b0;
    rob_commit_enable = 1'b0; rob_commit_pos = '0; rob_head_pos = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
    bus.issue_enable = 1'b0; bus.issue_is_store = 1'b0; bus.issue_funct3 = '0;
    bus.issue_rob_pos = '0; bus.issue_rs1_val = '0; bus.issue_rs1_tag = '0;
    bus.issue_rs2_val = '0; bus.issue_rs2_tag = '0; bus.issue_imm = '0;
    bus.mem_done = 1'b0; bus.mem_load_val = '0;
    @(negedge clk);
    test_reset();
    test_load_ext();
    test_store_commit();
    test_io_load();
    test_flush_commit();
    test_drain();
    test_rdy_freeze();
    test_full_wrap();
    test_reset_midwait();
    cycles(4);
    n_checks++; if (exp_req.size() != 0) $display("FAIL pending_requests got %0d want 0", exp_req.size()); else n_pass++;
    n_checks++; if (exp_out.size() != 0) $display("FAIL pending_results got %0d want 0", exp_out.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
